note_sequencer: RTL
===================

// Module: note_sequencer
// PURPOSE
//   Parametrised chart player for the rhythm-game note path. Holds up to MAX_NOTES
//   entries (hit time, lane, length) written at load time, runs a song-time counter
//   and releases each note in index order on a valid/ready stream once it is due.
//   Sits between chart loading and the falling-note renderer / hit judge.
// PARAMETERS
//   MAX_NOTES  32  chart depth (entries); IDX_W = $clog2(MAX_NOTES)
//   TIME_W     21  width of note hit time and song_time (ticks)
//   LANE_W     11  width of lane field (lane x-position)
//   LEN_W       6  width of note length field
//   LEAD      64  ticks before hit time at which a note is released (0 allowed)
// PORTS
//   clk         in   1          system clock
//   reset       in   1          asynchronous, active-high reset
//   wr_en       in   1          write chart entry (accepted only in IDLE)
//   wr_addr     in   IDX_W      entry index
//   wr_time     in   TIME_W     entry hit time
//   wr_lane     in   LANE_W     entry lane
//   wr_len      in   LEN_W      entry length
//   num_notes   in   IDX_W+1    entries to play (0..MAX_NOTES), sampled on start
//   start       in   1          1-cycle pulse: begin playback from song_time 0
//   pause       in   1          level: freeze song time and releases while high
//   tick        in   1          song-time strobe (one per game tick)
//   note_valid  out  1          output note present
//   note_ready  in   1          consumer accepts note this cycle
//   note_time / note_lane / note_len  out  TIME_W/LANE_W/LEN_W  released note fields
//   song_time   out  TIME_W     current song time
//   busy        out  1          state is PLAY or PAUSED
//   done        out  1          state is DONE
// BEHAVIOUR
//   Reset (async): state IDLE, song_time 0, ptr 0, note_valid 0, note_* 0, busy 0,
//     done 0. Chart storage is NOT reset; contents must be reloaded.
//   States: IDLE, PLAY, PAUSED, DONE.
//   IDLE: wr_en writes mem[wr_addr] next edge; wr_addr >= MAX_NOTES ignored.
//     start -> PLAY with song_time 0, ptr 0, count latched = min(num_notes, MAX_NOTES);
//     start with num_notes 0 -> DONE directly.
//   wr_en outside IDLE ignored. start outside IDLE/DONE ignored; start in DONE
//     replays the loaded chart as from IDLE.
//   PLAY: tick -> song_time+1, saturating at all-ones.
//     due = (ptr < count) && ({1'b0,song_time} + LEAD >= {1'b0,mem[ptr].time}),
//     computed TIME_W+1 bits wide, combinational on registered song_time.
//     Output register loads mem[ptr], ptr+1, when due && (!note_valid || note_ready);
//     so note_valid rises the cycle after song_time reaches the due value, and
//     ready held high gives one note per cycle (same-time notes back-to-back).
//   note_valid && !note_ready: note_* held stable, ptr frozen, later notes wait.
//   Handshake without reload clears note_valid next edge.
//   Order is index order; entries must be time-nondecreasing. An out-of-order
//     entry is released as soon as it is due and blocks later entries until then.
//   pause high in PLAY -> PAUSED next edge: tick ignored, no new loads; a pending
//     note stays valid and may still handshake. pause low -> PLAY next edge.
//   ptr == count && !note_valid (after final handshake) -> DONE next edge;
//     song_time holds. tick in DONE ignored.
//   Simultaneous tick and load: load uses pre-increment song_time.
// TESTING
//   Load {8,128,25},{128,256,36}, LEAD=0, num_notes 2, tick+ready every cycle ->
//     note0 valid cycle after song_time=8, note1 after song_time=128, done next.
//   ready=0 from first release, notes at 10 and 12 -> note0 held unchanged, ptr
//     stays 0; ready=1 at t=50 -> note0 then note1 on consecutive cycles.
//   Three entries all time 5, LEAD=0 -> valid on three consecutive cycles,
//     lanes in index order.
//   pause at song_time 4 for 20 cycles with tick high -> song_time stays 4,
//     no new notes; pause low -> counting resumes 5,6,...
//   num_notes 0 + start -> done=1 next cycle, note_valid never rises; start in
//     DONE with num_notes 2 -> replay from song_time 0.
//   reset asserted mid-PLAY with note_valid=1 -> all outputs 0 immediately, IDLE;
//     wr_en during PLAY leaves chart unchanged (verified by replay).

Source files
------------

// File: rtl/note_sequencer_if.sv
// Note output stream between the chart player and its consumer
// (falling-note renderer / hit judge).
//
// Handshake: the source raises note_valid with note_time/note_lane/note_len
// and holds all of them unchanged until a cycle where note_ready is also high.
// That cycle is the transfer. The sink may hold note_ready high without a note
// pending. note_valid never depends combinationally on note_ready.
//
// Signals:
//   note_valid  source -> sink  note present
//   note_ready  sink -> source  sink accepts this cycle
//   note_time   source -> sink  note hit time (ticks)
//   note_lane   source -> sink  lane x-position
//   note_len    source -> sink  note length
interface note_sequencer_if #(
  parameter int TIME_W = 21,
  parameter int LANE_W = 11,
  parameter int LEN_W  = 6
);
  logic              note_valid;
  logic              note_ready;
  logic [TIME_W-1:0] note_time;
  logic [LANE_W-1:0] note_lane;
  logic [LEN_W-1:0]  note_len;

  modport master (
    output note_valid, note_time, note_lane, note_len,
    input  note_ready
  );

  modport slave (
    input  note_valid, note_time, note_lane, note_len,
    output note_ready
  );
endinterface

// File: rtl/note_sequencer.sv
// Chart player for the rhythm-game note path. A chart of up to MAX_NOTES
// entries (hit time, lane, length) is written while idle. A start pulse then
// runs a song-time counter and releases the entries in index order on the note
// stream, each one LEAD ticks before its hit time.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_time/wr_lane/wr_len  chart write port (used only in IDLE)
//   num_notes         entries to play, sampled on start
//   start             one-cycle pulse: play from song time 0 (IDLE or DONE)
//   pause             level: freeze song time and releases
//   tick              song-time strobe
//   note              note stream (master side)
//   song_time         current song time
//   busy, done        PLAY/PAUSED, DONE
//   state_dbg         current FSM state (IDLE=0, PLAY=1, PAUSED=2, DONE=3)
module note_sequencer #(
  parameter int MAX_NOTES = 32,
  parameter int TIME_W    = 21,
  parameter int LANE_W    = 11,
  parameter int LEN_W     = 6,
  parameter int LEAD      = 64,
  localparam int IDX_W    = $clog2(MAX_NOTES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [TIME_W-1:0] wr_time,
  input  logic [LANE_W-1:0] wr_lane,
  input  logic [LEN_W-1:0]  wr_len,
  input  logic [IDX_W:0]    num_notes,
  input  logic              start,
  input  logic              pause,
  input  logic              tick,
  note_sequencer_if.master  note,
  output logic [TIME_W-1:0] song_time,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, PAUSED = 2'd2, DONE = 2'd3} state_t;

  localparam logic [IDX_W:0]  MAX_CNT = (IDX_W+1)'(MAX_NOTES);
  localparam logic [TIME_W:0] LEAD_X  = (TIME_W+1)'(LEAD);

  state_t state, state_n;

  // Chart storage has no reset; it must be reloaded after power-up.
  logic [TIME_W-1:0] mem_time [MAX_NOTES];
  logic [LANE_W-1:0] mem_lane [MAX_NOTES];
  logic [LEN_W-1:0]  mem_len  [MAX_NOTES];

  logic [IDX_W:0]    ptr, count, count_in;
  logic [IDX_W-1:0]  ptr_idx;
  logic [TIME_W-1:0] cur_time;
  logic              out_valid;
  logic [TIME_W-1:0] out_time;
  logic [LANE_W-1:0] out_lane;
  logic [LEN_W-1:0]  out_len;
  logic              due, load, hs, start_ok;

  assign ptr_idx  = ptr[IDX_W-1:0];
  assign cur_time = mem_time[ptr_idx];
  assign count_in = (num_notes > MAX_CNT) ? MAX_CNT : num_notes;
  assign start_ok = start && (state == IDLE || state == DONE);
  assign hs       = out_valid && note.note_ready;

  // One bit wider than song time so song_time + LEAD cannot wrap.
  assign due = (ptr < count) && (({1'b0, song_time} + LEAD_X) >= {1'b0, cur_time});

  always_ff @(posedge clk) begin
    if (state == IDLE && wr_en && ({1'b0, wr_addr} < MAX_CNT)) begin
      mem_time[wr_addr] <= wr_time;
      mem_lane[wr_addr] <= wr_lane;
      mem_len[wr_addr]  <= wr_len;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) state_n = (count_in == '0) ? DONE : PLAY;
      end
      PLAY: begin
        // The output register refills in the same cycle it is consumed.
        load = due && (!out_valid || note.note_ready);
        if (ptr == count && !out_valid) state_n = DONE;
        else if (pause)                 state_n = PAUSED;
      end
      PAUSED: begin
        if (!pause) state_n = PLAY;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      song_time <= '0;
      ptr       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_time  <= '0;
      out_lane  <= '0;
      out_len   <= '0;
    end else if (start_ok) begin
      song_time <= '0;
      ptr       <= '0;
      count     <= count_in;
      out_valid <= 1'b0;
    end else begin
      // Saturates at all-ones. A load in the same cycle sees the old value.
      if (state == PLAY && tick && song_time != '1) song_time <= song_time + 1'b1;
      if (load) begin
        out_valid <= 1'b1;
        out_time  <= cur_time;
        out_lane  <= mem_lane[ptr_idx];
        out_len   <= mem_len[ptr_idx];
        ptr       <= ptr + 1'b1;
      end else if (hs) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign note.note_valid = out_valid;
  assign note.note_time  = out_time;
  assign note.note_lane  = out_lane;
  assign note.note_len   = out_len;
  assign busy      = (state == PLAY) || (state == PAUSED);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule
